// File: rtl/sync_dp_ram.sv
// sync_dp_ram: single-clock dual-port RAM with a registered read port,
// per-byte write enables and a post-reset clear sequence.
// Optional feature macro: SYNC_DP_RAM_BYPASS_EN
//   defined   -> write-first on a same-address collision (read sees merged word)
//   undefined -> read-first on a same-address collision (read sees old word)
module sync_dp_ram #(
   parameter int                   DATAWIDTH  = 16,
   parameter int                   ASIZE      = 3,
   parameter logic [DATAWIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wen,
   input  logic [ASIZE-1:0]       waddr,
   input  logic [DATAWIDTH-1:0]   wdata,
   input  logic [DATAWIDTH/8-1:0] wbe,
   input  logic                   ren,
   input  logic [ASIZE-1:0]       raddr,
   output logic [DATAWIDTH-1:0]   rdata,
   output logic                   rvalid,
   output logic                   init_done
);

   localparam int DEPTH = 1 << ASIZE;
   localparam int NB    = DATAWIDTH / 8;

   typedef enum logic {
      ST_INIT,
      ST_READY
   } state_e;

   state_e                 state_q,     state_d;
   logic [ASIZE-1:0]       clr_cnt_q,   clr_cnt_d;
   logic [DATAWIDTH-1:0]   rdata_q,     rdata_d;
   logic                   rvalid_q,    rvalid_d;
   logic                   init_done_q, init_done_d;

   logic [DATAWIDTH-1:0]   mem_q [DEPTH];

   // Single internal write port shared by the clear loop and user writes.
   logic [NB-1:0]          mem_be;
   logic [ASIZE-1:0]       mem_addr;
   logic [DATAWIDTH-1:0]   mem_wdata;

   // Next-state logic: clear sequencing in INIT, user write steering in READY.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      init_done_d = init_done_q;
      mem_be      = '0;
      mem_addr    = clr_cnt_q;
      mem_wdata   = INIT_VALUE;
      case (state_q)
         ST_INIT: begin
            // wen/ren are deliberately ignored until the clear completes.
            mem_be    = '1;
            clr_cnt_d = clr_cnt_q + ASIZE'(1);
            if (clr_cnt_q == '1) begin
               state_d     = ST_READY;
               init_done_d = 1'b1;
            end
         end
         ST_READY: begin
            if (wen) begin
               mem_be    = wbe;
               mem_addr  = waddr;
               mem_wdata = wdata;
            end
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // Read path: registered data plus a one-cycle valid pulse per accepted read.
   always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      if (state_q == ST_READY && ren) begin
         rvalid_d = 1'b1;
         rdata_d  = mem_q[raddr];
`ifdef SYNC_DP_RAM_BYPASS_EN
         // Write-first: forward the enabled lanes of a same-address write.
         if (wen && (waddr == raddr)) begin
            for (int i = 0; i < NB; i++) begin
               if (wbe[i]) rdata_d[8*i +: 8] = wdata[8*i +: 8];
            end
         end
`endif
      end
   end

   // Control and read-port registers; synchronous reset restarts the clear.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q     <= ST_INIT;
         clr_cnt_q   <= '0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         init_done_q <= init_done_d;
      end
   end

   // Storage array with per-byte-lane write enables.
   always_ff @(posedge clk) begin
      // NOTE: the array has no reset term; it stays a plain RAM and the
      // clear sequence after reset provides the known contents instead.
      if (!rst) begin
         for (int i = 0; i < NB; i++) begin
            if (mem_be[i]) mem_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
         end
      end
   end

   assign rdata     = rdata_q;
   assign rvalid    = rvalid_q;
   assign init_done = init_done_q;

endmodule
